// File: rtl/gonso_wb_master_if.sv
// gonso_wb_master_if: command/response and Wishbone classic signals of the
// gonso Wishbone initiator. The master modport is the initiator's view. The
// slave modport is the view of the requester plus the bus slave.
interface gonso_wb_master_if;
    // command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    // response side
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    // Wishbone master side
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, busy,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, busy,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/gonso_wb_master.sv
// gonso_wb_master: Wishbone classic initiator. Queued commands are run one at
// a time as single read/write cycles, and each command produces one response.
// Optional feature macro: GONSO_WBM_TIMEOUT_EN. When it is defined, a
// watchdog aborts a BUS cycle after TO_CYCLES clocks without an ack.
module gonso_wb_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_CYCLES  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    gonso_wb_master_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // command FIFO storage and pointers; the extra MSB separates full from empty
    cmd_t        fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    cmd_t        head;

    state_t      state_reg;
    logic        cyc_reg;
    logic        we_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;
    logic [3:0]  sel_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_dat_reg;
    logic        rsp_err_reg;

`ifdef GONSO_WBM_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES);
    logic [CW-1:0] to_cnt_reg;
`else
    // no watchdog in this build; TO_CYCLES only has to be accepted
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES < 2);
`endif

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push  = bus.cmd_valid && !full;
    assign pop   = !empty && ((state_reg == IDLE) ||
                              (state_reg == RESP && bus.rsp_ready));
    assign head  = fifo_mem[rd_ptr_reg[AW-1:0]];

    // FIFO storage write; the contents need no reset because the pointers guard them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= '{we:  bus.cmd_we,  adr: bus.cmd_adr,
                                              dat: bus.cmd_dat, sel: bus.cmd_sel};
        end
    end

    // FIFO pointers; a push and a pop in the same cycle leave the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Bus/response FSM with registered Wishbone and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            sel_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef GONSO_WBM_TIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // leaving IDLE only happens through the pop below
                end
                BUS: begin
                    if (bus.wbm_ack_i) begin
                        cyc_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        rsp_dat_reg   <= we_reg ? 32'h0 : bus.wbm_dat_i;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
`ifdef GONSO_WBM_TIMEOUT_EN
                    else if (to_cnt_reg == CW'(TO_CYCLES - 1)) begin
                        // slave never answered: abandon the cycle and report it
                        cyc_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        rsp_dat_reg   <= 32'h0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Starting the next command overrides the IDLE target chosen above
            if (pop) begin
                adr_reg   <= head.adr;
                dat_reg   <= head.dat;
                sel_reg   <= head.sel;
                we_reg    <= head.we;
                cyc_reg   <= 1'b1;
                state_reg <= BUS;
`ifdef GONSO_WBM_TIMEOUT_EN
                to_cnt_reg <= '0;
`endif
            end
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state_reg != IDLE);
    assign bus.wbm_cyc_o = cyc_reg;
    assign bus.wbm_stb_o = cyc_reg;
    assign bus.wbm_we_o  = we_reg;
    assign bus.wbm_adr_o = adr_reg;
    assign bus.wbm_dat_o = dat_reg;
    assign bus.wbm_sel_o = sel_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_dat   = rsp_dat_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: doc/gonso_wb_master.md
# gonso_wb_master

Wishbone classic initiator for the gonso user project: it turns queued commands from an on-chip requester into single Wishbone read/write cycles and returns one response per command. It drives the same bus protocol the user-area slaves (including the gonso core) respond to, which lets a local agent exercise those slaves without the management SoC. Commands are buffered in a small FIFO, and an optional watchdog aborts cycles whose slave never acknowledges.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TO_CYCLES, 256, watchdog limit in clk cycles spent in BUS; ≥2
- clk  in  1  single clock; every register is clocked on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  32  read data (0 for writes and errors)
- rsp_err  out  1  watchdog abort
- busy  out  1  FIFO non-empty or FSM not IDLE
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_adr_o  out  32, wbm_dat_o  out  32, wbm_sel_o  out  4  Wishbone master address, data and selects
- wbm_ack_i  in  1, wbm_dat_i  in  32  slave acknowledge and read data

## Operation
- FIFO push on cmd_valid&&cmd_ready; cmd_ready = !full, independent of a same-cycle pop.
- FSM states:
  - IDLE, BUS, RESP; reset state IDLE.
  - Pop condition: (IDLE, or RESP with rsp_ready) and FIFO non-empty.
  - On pop: load wbm_adr_o/dat_o/sel_o/we_o from the FIFO head, set cyc_o=stb_o=1, clear the watchdog counter, go to BUS.
  - BUS, wbm_ack_i=1: clear cyc/stb/we; rsp_dat = we ? 0 : wbm_dat_i; rsp_err=0; rsp_valid=1; go to RESP.
  - RESP: hold the response until rsp_ready. Then go to BUS if a pop occurs, else to IDLE with rsp_valid=0.
- cyc_o and stb_o are always equal. The cycle is a single transfer; no bursts and no wbm_err_i.
- wbm_adr_o, wbm_dat_o and wbm_sel_o hold their last values outside BUS. wbm_we_o is 0 outside BUS.
- Reset values: all outputs 0 except cmd_ready=1. FIFO is empty, FSM is IDLE, counter is 0.

## Timing
- Command accepted at edge N with the FSM IDLE and the FIFO empty: cyc/stb are high after edge N+1.
- Ack sampled high at edge M: cyc/stb low and rsp_valid high after edge M. Ack in the first BUS cycle gives a one-cycle bus transaction.
- Back-to-back: rsp_ready high in the first RESP cycle with FIFO non-empty gives a one-cycle gap between cycles.
- FIFO wrap: pointers wrap modulo FIFO_DEPTH, with one extra pointer bit to distinguish full from empty. Push and pop in the same cycle keep the level unchanged.
- Asserting rst_n low mid-cycle immediately drops cyc/stb/rsp_valid, empties the FIFO and abandons the transfer; no response is produced.

## Configuration
- GONSO_WBM_TIMEOUT_EN defined:
  - The counter increments each BUS cycle without ack.
  - In the BUS cycle where the counter equals TO_CYCLES-1 and ack is low, the cycle aborts at that edge: cyc/stb drop, rsp_err=1, rsp_dat=0, state goes to RESP.
  - An ack in that same cycle takes priority and gives a normal response.
- Undefined: no counter logic. BUS waits indefinitely for ack and rsp_err is tied to 0.

## Test plan
- Reset with rst_n=0: cmd_ready=1 and every other output 0. Release reset: outputs unchanged, busy=0.
- Write: adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, slave acks on the 3rd BUS cycle -> wbm_we_o=1 for 3 cycles, then rsp_valid=1, rsp_dat=0, rsp_err=0.
- Read from adr 0x3000_0000, slave returns 0x1234_5678 with an immediate ack and rsp_ready held 1 -> cyc high for 1 cycle, rsp_dat=0x1234_5678.
- 5 commands pushed with rsp_ready=0 and no acks: cmd_ready falls after the 5th accept. Re-enable acks and rsp_ready: 5 responses return in order, and an edge-of-full push+pop keeps the level at 4.
- With GONSO_WBM_TIMEOUT_EN and TO_CYCLES=8, the slave never acks -> cyc drops after exactly 8 BUS cycles, rsp_err=1, rsp_dat=0. An ack in the 8th cycle -> rsp_err=0.
- Assert rst_n during BUS -> cyc/stb go to 0 asynchronously and no rsp_valid follows after release.
